// File: rtl/spectral_peak_picker_pkg.sv
// Shared definitions for the spectral peak picker.
//   state_t        : controller states
//   DEF_*          : default parameter values
//   RD_LAT         : read latency of the frame store, added to every SCAN pass
//   idx_w / cnt_w  : bin-index width and peak-count width derivations
//   frame_latency  : worst-case cycles from last load beat to out_valid
package spectral_peak_picker_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SCAN,
        ST_MASK,
        ST_DONE
    } state_t;

    localparam int DEF_N_BINS  = 512;
    localparam int DEF_DATA_W  = 25;
    localparam int DEF_N_PEAKS = 11;
    localparam int DEF_RADIUS  = 1;

    // The frame store has a registered read port, so each SCAN pass is
    // N_BINS + RD_LAT cycles long.
    localparam int RD_LAT = 1;

    function automatic int idx_w(input int n_bins);
        return $clog2(n_bins);
    endfunction

    function automatic int cnt_w(input int n_peaks);
        return $clog2(n_peaks + 1);
    endfunction

    function automatic int frame_latency(input int n_bins, input int n_peaks);
        return n_peaks * (n_bins + 1 + RD_LAT) + 1;
    endfunction

endpackage

// File: rtl/argmax_scan.sv
// Running arg-max tracker, one bin per cycle.
//   start    : this beat begins a new search (prior best discarded)
//   bin/mag  : bin index and magnitude of the current beat
//   masked   : beat is ignored (suppressed bin or no beat this cycle)
//   best_*   : best so far INCLUDING the current beat (combinational)
//   found    : at least one unmasked beat seen in this search
module argmax_scan #(
    parameter int IDX_W  = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [IDX_W-1:0]  bin,
    input  logic [DATA_W-1:0] mag,
    input  logic              masked,
    output logic [IDX_W-1:0]  best_idx,
    output logic [DATA_W-1:0] best_mag,
    output logic              found
);

    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] mag_q;
    logic              found_q;
    logic              base_found;
    logic              take;

    // Strict greater-than: with bins arriving in ascending order, ties keep
    // the lowest index.
    always_comb begin
        base_found = found_q && !start;
        take       = !masked && (!base_found || (mag > mag_q));
        found      = base_found || take;
        best_idx   = take ? bin : idx_q;
        best_mag   = take ? mag : mag_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q   <= '0;
            mag_q   <= '0;
            found_q <= 1'b0;
        end else begin
            idx_q   <= best_idx;
            mag_q   <= best_mag;
            found_q <= found;
        end
    end

endmodule

// File: rtl/spectral_peak_picker.sv
// Spectral peak picker: loads one frame of N_BINS magnitudes, then repeatedly
// finds the largest unsuppressed bin, records it, and suppresses +/-RADIUS
// bins around it, until N_PEAKS are found or the best falls below threshold.
//   clk, reset           : clock, synchronous active-high reset
//   in_valid/in_ready    : load handshake, in_data in bin order 0..N_BINS-1
//   threshold            : acceptance level, captured on the first load beat
//   out_valid/out_ready  : result handshake
//   out_idx/out_mag      : peak slots, descending magnitude, unused slots zero
//   out_count            : number of valid slots
//   busy                 : high whenever not IDLE
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for first beat of a frame; outputs of last frame held
// LOAD  | accepting remaining beats into the frame store
// SCAN  | one pass over all bins tracking the largest unmasked magnitude
// MASK  | suppress bins around the peak just recorded
// DONE  | result presented until out_ready
module spectral_peak_picker
    import spectral_peak_picker_pkg::*;
#(
    parameter int N_BINS  = DEF_N_BINS,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int N_PEAKS = DEF_N_PEAKS,
    parameter int RADIUS  = DEF_RADIUS
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [DATA_W-1:0]                         in_data,
    input  logic [DATA_W-1:0]                         threshold,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [N_PEAKS-1:0][idx_w(N_BINS)-1:0]     out_idx,
    output logic [N_PEAKS-1:0][DATA_W-1:0]            out_mag,
    output logic [cnt_w(N_PEAKS)-1:0]                 out_count,
    output logic                                      busy
);

    localparam int IDX_W = idx_w(N_BINS);
    localparam int CNT_W = cnt_w(N_PEAKS);
    localparam logic [IDX_W:0] RD_END   = (IDX_W+1)'(N_BINS);
    localparam logic [IDX_W:0] SCAN_END = (IDX_W+1)'(N_BINS - 1 + RD_LAT);

    state_t state_q, state_d;

    logic [DATA_W-1:0] mem [N_BINS];
    logic [DATA_W-1:0] rd_data;
    logic [IDX_W-1:0]  rd_bin_q;
    logic              rd_vld_q;

    logic [IDX_W-1:0]  wr_cnt;
    logic [IDX_W:0]    scan_cnt;
    logic [DATA_W-1:0] thr_q;
    logic [N_BINS-1:0] mask_q;
    logic [IDX_W-1:0]  peak_idx_q;

    logic [IDX_W-1:0]  best_idx;
    logic [DATA_W-1:0] best_mag;
    logic              found;
    logic              in_xfer;
    logic              scan_last;
    logic              accept;

    assign in_xfer   = in_valid && in_ready;
    assign scan_last = (state_q == ST_SCAN) && (scan_cnt == SCAN_END);
    assign accept    = scan_last && found && (best_mag >= thr_q);

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_xfer) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                in_ready = 1'b1;
                if (in_xfer && (wr_cnt == IDX_W'(N_BINS - 1))) state_d = ST_SCAN;
            end
            ST_SCAN: begin
                if (scan_last) state_d = accept ? ST_MASK : ST_DONE;
            end
            ST_MASK: begin
                state_d = (out_count == CNT_W'(N_PEAKS)) ? ST_DONE : ST_SCAN;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Frame store: written only during load, never touched by the search.
    always_ff @(posedge clk) begin
        if (in_xfer) mem[wr_cnt] <= in_data;
        rd_data <= mem[scan_cnt[IDX_W-1:0]];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cnt     <= '0;
            scan_cnt   <= '0;
            thr_q      <= '0;
            mask_q     <= '0;
            peak_idx_q <= '0;
            out_idx    <= '0;
            out_mag    <= '0;
            out_count  <= '0;
            rd_vld_q   <= 1'b0;
            rd_bin_q   <= '0;
        end else begin
            rd_vld_q <= (state_q == ST_SCAN) && (scan_cnt < RD_END);
            rd_bin_q <= scan_cnt[IDX_W-1:0];

            // Counter wraps to 0 on the last beat since N_BINS is a power of two.
            if (in_xfer) wr_cnt <= wr_cnt + 1'b1;

            if (in_xfer && (state_q == ST_IDLE)) begin
                thr_q     <= threshold;
                mask_q    <= '0;
                out_idx   <= '0;
                out_mag   <= '0;
                out_count <= '0;
            end

            if (state_q == ST_SCAN) scan_cnt <= scan_cnt + 1'b1;
            else                    scan_cnt <= '0;

            if (accept) begin
                for (int p = 0; p < N_PEAKS; p++) begin
                    if (CNT_W'(p) == out_count) begin
                        out_idx[p] <= best_idx;
                        out_mag[p] <= best_mag;
                    end
                end
                out_count  <= out_count + 1'b1;
                peak_idx_q <= best_idx;
            end

            // Bins outside 0..N_BINS-1 simply do not exist, so the window
            // clips at both ends without wrapping.
            if (state_q == ST_MASK) begin
                for (int b = 0; b < N_BINS; b++) begin
                    if ((b >= int'(peak_idx_q) - RADIUS) && (b <= int'(peak_idx_q) + RADIUS))
                        mask_q[b] <= 1'b1;
                end
            end
        end
    end

    argmax_scan #(
        .IDX_W  (IDX_W),
        .DATA_W (DATA_W)
    ) u_argmax (
        .clk      (clk),
        .reset    (reset),
        .start    (rd_vld_q && (rd_bin_q == '0)),
        .bin      (rd_bin_q),
        .mag      (rd_data),
        .masked   (!rd_vld_q || mask_q[rd_bin_q]),
        .best_idx (best_idx),
        .best_mag (best_mag),
        .found    (found)
    );

endmodule

// File: tb/tb_spectral_peak_picker.sv
// Randomized self-checking bench for spectral_peak_picker against a
// behavioural peak-list model.
module tb_spectral_peak_picker;
    import spectral_peak_picker_pkg::*;

    localparam int NB = 16;
    localparam int DW = 8;
    localparam int NP = 3;
    localparam int R  = 1;
    localparam int IW = 4;
    localparam int CW = 2;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   in_valid;
    logic                   in_ready;
    logic [DW-1:0]          in_data;
    logic [DW-1:0]          threshold;
    logic                   out_valid;
    logic                   out_ready;
    logic [NP-1:0][IW-1:0]  out_idx;
    logic [NP-1:0][DW-1:0]  out_mag;
    logic [CW-1:0]          out_count;
    logic                   busy;

    spectral_peak_picker #(
        .N_BINS (NB), .DATA_W (DW), .N_PEAKS (NP), .RADIUS (R)
    ) dut (
        .clk (clk), .reset (reset),
        .in_valid (in_valid), .in_ready (in_ready), .in_data (in_data),
        .threshold (threshold),
        .out_valid (out_valid), .out_ready (out_ready),
        .out_idx (out_idx), .out_mag (out_mag), .out_count (out_count),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    logic [DW-1:0] frame [NB];
    logic [DW-1:0] thr;
    int exp_cnt;
    int exp_idx [NP];
    int exp_mag [NP];

    // Peak list straight from the rules: repeatedly take the largest
    // unsuppressed bin (lowest index on ties), stop below threshold.
    task automatic model();
        bit m [NB];
        int best, bm;
        for (int b = 0; b < NB; b++) m[b] = 1'b0;
        exp_cnt = 0;
        for (int p = 0; p < NP; p++) begin exp_idx[p] = 0; exp_mag[p] = 0; end
        for (int p = 0; p < NP; p++) begin
            best = -1; bm = 0;
            for (int b = 0; b < NB; b++)
                if (!m[b] && (best < 0 || int'(frame[b]) > bm)) begin best = b; bm = int'(frame[b]); end
            if (best < 0 || bm < int'(thr)) break;
            exp_idx[p] = best; exp_mag[p] = bm; exp_cnt++;
            for (int b = best - R; b <= best + R; b++)
                if (b >= 0 && b < NB) m[b] = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic fill(input logic [DW-1:0] v);
        for (int b = 0; b < NB; b++) frame[b] = v;
    endtask

    // abort_at > 0: assert reset together with that load beat and return.
    task automatic load_frame(input int gap_pct, input int abort_at);
        int i = 0;
        int guard = 0;
        bit xfer;
        while (i < NB && guard < 2000) begin
            in_valid  = ($urandom_range(0, 99) >= gap_pct);
            in_data   = frame[i];
            threshold = (i == 0) ? thr : DW'($urandom);
            xfer = in_valid && in_ready;
            if (abort_at > 0 && xfer && i == abort_at - 1) reset = 1'b1;
            tick();
            guard++;
            if (reset) begin reset = 1'b0; in_valid = 1'b0; return; end
            if (xfer) i++;
        end
        in_valid = 1'b0;
        if (i < NB) check("load_timeout", i, NB);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_cnt"}, out_count, exp_cnt);
        for (int s = 0; s < NP; s++) begin
            check($sformatf("%s_idx%0d", tag, s), out_idx[s], exp_idx[s]);
            check($sformatf("%s_mag%0d", tag, s), out_mag[s], exp_mag[s]);
        end
    endtask

    task automatic wait_done(input string tag);
        int lat = 0;
        int lat_exp;
        while (!out_valid && lat < 200) begin tick(); lat++; end
        check({tag, "_done"}, out_valid, 1);
        check({tag, "_lat_bound"}, lat <= frame_latency(NB, NP), 1);
        lat_exp = exp_cnt * (NB + RD_LAT + 1) + ((exp_cnt < NP) ? (NB + RD_LAT) : 0);
        check({tag, "_lat"}, lat, lat_exp);
    endtask

    task automatic handshake(input string tag, input int hold);
        out_ready = 1'b0;
        for (int c = 0; c < hold; c++) begin
            in_valid = 1'b1;
            in_data  = DW'($urandom);
            check({tag, "_hold_valid"}, out_valid, 1);
            check({tag, "_hold_ready"}, in_ready, 0);
            check({tag, "_hold_busy"}, busy, 1);
            check({tag, "_hold_cnt"}, out_count, exp_cnt);
            check({tag, "_hold_idx0"}, out_idx[0], exp_idx[0]);
            check({tag, "_hold_mag0"}, out_mag[0], exp_mag[0]);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check({tag, "_post_valid"}, out_valid, 0);
        check({tag, "_post_ready"}, in_ready, 1);
        check({tag, "_post_busy"}, busy, 0);
    endtask

    task automatic run_frame(input string tag, input int gap_pct, input int hold);
        model();
        load_frame(gap_pct, 0);
        wait_done(tag);
        check_outputs(tag);
        handshake(tag, hold);
    endtask

    task automatic set_req027();
        fill(8'd1);
        frame[5] = 8'd100; frame[6] = 8'd90; frame[12] = 8'd50; frame[0] = 8'd40;
        thr = 8'd10;
    endtask

    bit watch = 1'b0;
    bit bad_out = 1'b0;
    always @(posedge clk) if (watch && out_valid) bad_out = 1'b1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; threshold = '0; out_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_count", out_count, 0);
        check("rst_idx", out_idx, 0);
        check("rst_mag", out_mag, 0);

        set_req027();
        run_frame("req027", 0, 0);
        check("req027_model_cnt", exp_cnt, 3);

        fill(8'd1); frame[3] = 8'd20; thr = 8'd10;
        run_frame("req028", 0, 1);

        fill(8'd1); frame[15] = 8'd200; frame[0] = 8'd200; thr = 8'd10;
        run_frame("req029", 0, 0);

        fill(8'd1); frame[7] = 8'd10; thr = 8'd10;
        run_frame("thr_eq", 0, 0);

        set_req027();
        run_frame("req030", 0, 20);
        fill(8'd1); frame[9] = 8'd77; frame[2] = 8'd33; thr = 8'd10;
        run_frame("after030", 0, 0);

        // Reset at the 8th load beat, then again in the middle of SCAN.
        watch = 1'b1;
        set_req027();
        load_frame(0, 8);
        check("abort_load_ready", in_ready, 1);
        check("abort_load_busy", busy, 0);
        load_frame(0, 0);
        repeat (6) tick();
        check("mid_scan_busy", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_scan_ready", in_ready, 1);
        check("abort_scan_busy", busy, 0);
        check("abort_scan_cnt", out_count, 0);
        repeat (80) tick();
        watch = 1'b0;
        check("abort_no_out_valid", bad_out, 0);
        set_req027();
        run_frame("req031", 0, 0);

        set_req027();
        run_frame("req032", 50, 2);

        for (int f = 0; f < 25; f++) begin
            for (int b = 0; b < NB; b++) frame[b] = DW'($urandom_range(0, 40));
            thr = DW'($urandom_range(0, 40));
            run_frame($sformatf("rnd%0d", f), $urandom_range(0, 60), $urandom_range(0, 4));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spectral_peak_picker.md
SPECTRAL_PEAK_PICKER -- requirements
Module: spectral_peak_picker

Interface
REQ-001 SHALL have parameter N_BINS, default 512, bins per spectrum frame (power of two, >= 4).
REQ-002 SHALL have parameter DATA_W, default 25, magnitude width (unsigned).
REQ-003 SHALL have parameter N_PEAKS, default 11, maximum peaks reported per frame (1..N_BINS).
REQ-004 SHALL have parameter RADIUS, default 1, suppression half-width in bins around each accepted peak (0..N_BINS/2).
REQ-005 SHALL have ports clk in 1 system clock; reset in 1 synchronous active-high reset; one clock, no other clock domains.
REQ-006 SHALL have ports in_valid in 1; in_ready out 1; in_data in DATA_W magnitude beat, bin order 0..N_BINS-1.
REQ-007 SHALL have port threshold in DATA_W; minimum magnitude for a peak to be accepted, sampled at the first accepted load beat.
REQ-008 SHALL have ports out_valid out 1; out_ready in 1; out_idx out N_PEAKS x IDX_W (IDX_W=clog2(N_BINS)); out_mag out N_PEAKS x DATA_W; out_count out clog2(N_PEAKS+1) valid peaks.
REQ-009 SHALL have port busy out 1, high in every state except IDLE.

Function
REQ-010 SHALL implement states IDLE, LOAD, SCAN, MASK, DONE.
REQ-011 A beat SHALL transfer when in_valid && in_ready; in_ready = 1 only in IDLE and LOAD.
REQ-012 IDLE -> LOAD on first transfer; after the N_BINS-th transfer (bin counter wraps to 0), next state SCAN; no gap beats needed, in_valid low stalls without loss.
REQ-013 Each load SHALL clear the per-bin mask vector and the peak list; the previous frame's outputs are discarded only once in DONE handshake completes (new load impossible before).
REQ-014 SCAN SHALL visit every bin once, one bin per cycle (N_BINS cycles), tracking the largest unmasked magnitude; ties resolve to the lowest index (strict greater-than update).
REQ-015 After SCAN: if no unmasked bin exists or best < threshold -> DONE; else record idx/mag at slot out_count, increment count, go MASK.
REQ-016 MASK (1 cycle) SHALL set mask bits for bins max(0,idx-RADIUS)..min(N_BINS-1,idx+RADIUS), clipped at both edges, no wrap-around.
REQ-017 From MASK: if count == N_PEAKS -> DONE, else -> SCAN.
REQ-018 Worst-case frame latency from last load beat to out_valid: N_PEAKS*(N_BINS+1)+1 cycles; magnitude equal to threshold SHALL be accepted.
REQ-019 In DONE, out_valid = 1 and out_idx/out_mag/out_count SHALL hold stable until out_valid && out_ready, then -> IDLE the next cycle.
REQ-020 Slots >= out_count SHALL read zero; peaks reported in descending magnitude order.
REQ-021 Stored data SHALL never be overwritten during search; masking uses a separate N_BINS-bit vector.

Reset
REQ-022 reset SHALL, synchronously, force IDLE, clear counters, count, mask vector, out_idx, out_mag; out_valid=0, busy=0, in_ready=1 after the reset cycle.
REQ-023 reset asserted in any state (mid-load, mid-scan, DONE awaiting out_ready) SHALL abort the frame with no output; reset dominates simultaneous in_valid/out_ready.

Structure
REQ-024 A shared package SHALL hold the state enum, IDX_W/count-width derivation functions and default parameter constants.
REQ-025 A sub-module argmax_scan SHALL implement the per-cycle compare/track (start, bin, mag, masked in; best_idx, best_mag, found out).
REQ-026 Frame storage SHALL be a single-read single-write array inferable as block RAM (registered read allowed; latency absorbed in SCAN, adjusting REQ-018 by a constant declared in the package).

Verification (N_BINS=16, DATA_W=8, N_PEAKS=3, RADIUS=1, threshold=10)
REQ-027 Bins 5=100, 6=90, 12=50, 0=40, rest 1 -> out_idx {5,12,0}, out_mag {100,50,40}, out_count=3 (bin 6 suppressed).
REQ-028 All bins 1 except bin 3=20 -> out_count=1, out_idx[0]=3, slots 1..2 zero, early DONE after 2 scans.
REQ-029 Bins 15=200, 0=200 -> tie picks 0 first, then 15 (edge clip, no wrap), out_count=2.
REQ-030 out_ready held low 20 cycles in DONE -> outputs stable, in_ready=0, next frame accepted only after handshake.
REQ-031 reset pulsed at 8th load beat and again mid-SCAN -> IDLE, out_valid never asserted, following clean frame gives correct result.
REQ-032 in_valid toggled randomly during load -> result identical to REQ-027 with unbroken stream.
